fsk_frame_sequencer: RTL and testbench
======================================

// Module: fsk_frame_sequencer
// PURPOSE
//  Sequences the 64-entry FSK waveform table lookup feeding the ZMOD DAC driver. Accepts bytes over a
//  valid/ready handshake and serialises each as a UART-style frame (start, 8 data LSB-first, stop).
//  Selects the per-sample table index step (mark/space/idle) and owns the phase-continuous index
//  accumulator. Sits between the byte source and the waveform ROM in the clk100mhz domain.
// PARAMETERS
//  SAMPLES_PER_BIT  1000  clk cycles per transmitted bit; must be >= 2
//  STEP_MARK        10    index increment per cycle for a '1' bit and the stop bit
//  STEP_SPACE       5     index increment per cycle for a '0' bit and the start bit
//  STEP_IDLE        1     index increment per cycle while no frame is in progress
// PORTS
//  clk100mhz      in   1  system/sample clock
//  rst            in   1  synchronous, active-high reset
//  i8_data        in   8  byte to transmit
//  i_valid        in   1  i8_data valid
//  o_ready        out  1  sequencer can accept a byte this cycle
//  i_abort        in   1  synchronous abort of the current frame
//  o6_mem_index   out  6  waveform table read index (registered)
//  o6_step        out  6  step currently applied (registered)
//  o_mark         out  1  1 while a mark symbol (data '1' or stop) is transmitted
//  o_busy         out  1  1 while state != IDLE
//  o_frame_done   out  1  one-cycle pulse at the end of the stop bit
// BEHAVIOUR
//  Reset: state IDLE, o6_mem_index=0, o6_step=STEP_IDLE, o_mark=0, o_busy=0, o_frame_done=0, counters 0.
//  States: IDLE -> START -> DATA -> STOP -> IDLE.
//  o_ready = (state==IDLE) && !i_abort (combinational); accept = i_valid && o_ready; byte latched on accept.
//  Accept in IDLE: next cycle state=START, o6_step=STEP_SPACE, o_busy=1, sample counter=0.
//  Sample counter runs 0..SAMPLES_PER_BIT-1; terminal count (TC) ends the current bit.
//  START@TC -> DATA, bit counter=0. DATA@TC: bit counter 7 -> STOP, else bit counter+1.
//  STOP@TC -> IDLE; o_frame_done=1 in the first IDLE cycle; o6_step=STEP_IDLE.
//  Step per state: START=STEP_SPACE; DATA=bit?STEP_MARK:STEP_SPACE (bit = latched byte[bit counter]);
//    STOP=STEP_MARK; IDLE=STEP_IDLE. o6_step and o_mark update in the same cycle as the state change.
//  Accumulator: every cycle o6_mem_index <= o6_mem_index + o6_step, modulo 64 (no reset on symbol
//    change; phase is continuous across bits, frames and idle).
//  Frame length: exactly 10*SAMPLES_PER_BIT cycles with o_busy=1; at least one IDLE cycle between frames
//    (o_ready is low in STOP, so back-to-back bytes are separated by one cycle).
//  i_abort in any non-IDLE state: next cycle state=IDLE, o6_step=STEP_IDLE, o_mark=0, no o_frame_done,
//    latched byte discarded; accumulator keeps running. i_abort with i_valid in IDLE: not accepted.
//  i_valid outside IDLE is ignored (no accept); i8_data is sampled only on accept.
//  rst mid-frame: all registers return to reset values on the next edge, including o6_mem_index=0.
// TESTING (SAMPLES_PER_BIT=4 unless noted)
//  Reset then idle 20 cycles -> o6_mem_index = 0,1,2,...,19; o_ready=1; o_busy=0; o6_step=1.
//  Send 8'hA5 at cycle t -> o6_step: 5 for 4 cycles, then bits 1,0,1,0,0,1,0,1 as 10/5 per 4 cycles,
//    then 10 for 4; o_frame_done at t+41; o_busy high exactly 40 cycles.
//  Accumulator wrap: index 60 with step 10 -> next index 6; no discontinuity at symbol boundaries.
//  Two bytes, i_valid held high -> second accepted exactly 1 cycle after o_frame_done cycle's IDLE entry;
//    frames separated by one STEP_IDLE cycle.
//  i_abort during DATA bit 3 -> next cycle o_busy=0, o6_step=1, no o_frame_done; new byte accepted after.
//  rst asserted mid-STOP -> next cycle o6_mem_index=0, o6_step=1, o_busy=0, o_mark=0, o_ready=1.

Source files
------------

// File: rtl/fsk_frame_sequencer.sv
// FSK frame sequencer: serialises bytes as UART-style frames and drives
// the phase-continuous waveform table index for the DAC path.
module fsk_frame_sequencer #(
  parameter int         SAMPLES_PER_BIT = 1000,
  parameter logic [5:0] STEP_MARK       = 6'd10,
  parameter logic [5:0] STEP_SPACE      = 6'd5,
  parameter logic [5:0] STEP_IDLE       = 6'd1
) (
  input  logic       clk100mhz,
  input  logic       rst,
  input  logic [7:0] i8_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_abort,
  output logic [5:0] o6_mem_index,
  output logic [5:0] o6_step,
  output logic       o_mark,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] TC = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] samp_q;
  logic [2:0]    bit_q;
  logic [5:0]    index_q;
  logic [5:0]    step_q;
  logic          mark_q;
  logic          done_q;

  logic       accept;
  logic       tc;
  logic [2:0] bit_d;

  assign o_ready = (state_q == IDLE) && !i_abort;
  assign accept  = i_valid && o_ready;
  assign tc      = (samp_q == TC);
  assign bit_d   = bit_q + 3'd1;

  assign o6_mem_index = index_q;
  assign o6_step      = step_q;
  assign o_mark       = mark_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = done_q;

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      index_q <= '0;
      step_q  <= STEP_IDLE;
      mark_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Phase runs continuously; only reset clears it.
      index_q <= index_q + step_q;
      done_q  <= 1'b0;
      if (state_q != IDLE && i_abort) begin
        state_q <= IDLE;
        byte_q  <= '0;
        samp_q  <= '0;
        bit_q   <= '0;
        step_q  <= STEP_IDLE;
        mark_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= START;
              byte_q  <= i8_data;
              samp_q  <= '0;
              step_q  <= STEP_SPACE;
              mark_q  <= 1'b0;
            end
          end
          START: begin
            if (tc) begin
              state_q <= DATA;
              samp_q  <= '0;
              bit_q   <= '0;
              step_q  <= byte_q[0] ? STEP_MARK : STEP_SPACE;
              mark_q  <= byte_q[0];
            end else begin
              samp_q <= samp_q + CW'(1);
            end
          end
          DATA: begin
            if (tc) begin
              samp_q <= '0;
              if (bit_q == 3'd7) begin
                state_q <= STOP;
                step_q  <= STEP_MARK;
                mark_q  <= 1'b1;
              end else begin
                bit_q  <= bit_d;
                step_q <= byte_q[bit_d] ? STEP_MARK : STEP_SPACE;
                mark_q <= byte_q[bit_d];
              end
            end else begin
              samp_q <= samp_q + CW'(1);
            end
          end
          STOP: begin
            if (tc) begin
              state_q <= IDLE;
              samp_q  <= '0;
              step_q  <= STEP_IDLE;
              mark_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              samp_q <= samp_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_frame_sequencer.sv
// Bench for fsk_frame_sequencer: directed scenarios plus random traffic
// against a frame-position reference model.
module tb_fsk_frame_sequencer;

  localparam int SPB = 4;

  logic       clk100mhz = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i8_data = '0;
  logic       i_valid = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_ready;
  logic [5:0] o6_mem_index;
  logic [5:0] o6_step;
  logic       o_mark;
  logic       o_busy;
  logic       o_frame_done;

  int checks = 0;
  int errors = 0;

  fsk_frame_sequencer #(
    .SAMPLES_PER_BIT(SPB),
    .STEP_MARK(6'd10),
    .STEP_SPACE(6'd5),
    .STEP_IDLE(6'd1)
  ) dut (
    .clk100mhz(clk100mhz),
    .rst(rst),
    .i8_data(i8_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_abort(i_abort),
    .o6_mem_index(o6_mem_index),
    .o6_step(o6_step),
    .o_mark(o_mark),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done)
  );

  always #5 clk100mhz = ~clk100mhz;

  // Reference: a frame is a position 0..10*SPB-1; symbol = pos/SPB.
  int         m_idx = 0;
  int         m_step = 1;
  int         m_pos = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_mark = 0;
  logic [7:0] m_byte = '0;

  always @(posedge clk100mhz) begin
    int sym;
    bit bv;
    if (rst) begin
      m_idx = 0;
      m_active = 0;
      m_pos = 0;
      m_done = 0;
    end else begin
      m_idx = (m_idx + m_step) % 64;
      m_done = 0;
      if (m_active) begin
        if (i_abort) m_active = 0;
        else begin
          m_pos++;
          if (m_pos == 10 * SPB) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end else if (i_valid && !i_abort) begin
        m_active = 1;
        m_pos = 0;
        m_byte = i8_data;
      end
    end
    sym = m_pos / SPB;
    bv = (sym == 0) ? 1'b0 : (sym == 9) ? 1'b1 : m_byte[sym-1];
    m_step = !m_active ? 1 : (bv ? 10 : 5);
    m_mark = m_active && bv;
  end

  logic [15:0] dvec;
  assign dvec = {o_ready, o_busy, o_mark, o_frame_done, o6_step, o6_mem_index};

  function automatic logic [15:0] mvec();
    return {!m_active && !i_abort, m_active, m_mark, m_done,
            6'(m_step), 6'(m_idx)};
  endfunction

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (o6_mem_index !== 6'd0 || o6_step !== 6'd1 || o_busy !== 1'b0 ||
        o_mark !== 1'b0 || o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: idx=%0d step=%0d busy=%b mark=%b done=%b, need 0 1 0 0 0",
               o6_mem_index, o6_step, o_busy, o_mark, o_frame_done);
    end
    rst = 1'b0;
    for (int k = 1; k < 20; k++) begin
      tick();
      checks++;
      if (o6_mem_index !== 6'(k) || o_ready !== 1'b1 || o_busy !== 1'b0 ||
          o6_step !== 6'd1) begin
        errors++;
        $display("FAIL idle_count k=%0d: idx=%0d ready=%b busy=%b step=%0d, need %0d 1 0 1",
                 k, o6_mem_index, o_ready, o_busy, o6_step, k);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    int done_at = -1;
    int busy_cnt = 0;
    int exp_step;
    int sym;
    i8_data = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i8_data = 8'h00;
    for (int j = 1; j <= 45; j++) begin
      sym = (j - 1) / SPB;
      if (j > 10 * SPB) exp_step = 1;
      else if (sym == 0) exp_step = 5;
      else if (sym == 9) exp_step = 10;
      else exp_step = b[sym-1] ? 10 : 5;
      checks++;
      if (o6_step !== 6'(exp_step) || dvec !== mvec()) begin
        errors++;
        $display("FAIL frame j=%0d: step=%0d vec=%h, need step %0d vec %h",
                 j, o6_step, dvec, exp_step, mvec());
      end
      if (o_busy) busy_cnt++;
      if (o_frame_done && done_at < 0) done_at = j;
      if (j < 45) tick();
    end
    checks++;
    if (done_at != 41 || busy_cnt != 40) begin
      errors++;
      $display("FAIL frame_len: done_at=%0d busy=%0d, need 41 40", done_at, busy_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] pi;
    logic [5:0] ps;
    bit seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i8_data = 8'hFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      pi = o6_mem_index;
      ps = o6_step;
      tick();
      checks++;
      if (o6_mem_index !== 6'((int'(pi) + int'(ps)) % 64) || dvec !== mvec()) begin
        errors++;
        $display("FAIL accum j=%0d: idx=%0d, need %0d", j, o6_mem_index,
                 (int'(pi) + int'(ps)) % 64);
      end
      if (ps == 6'd10 && pi >= 6'd54) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_seen: got 0, need 1");
    end
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int dn = 0;
    i8_data = 8'h3C;
    i_valid = 1'b1;
    n = 0;
    while (!o_busy && n < 10) begin
      tick();
      n++;
    end
    i8_data = 8'hC3;
    n = 0;
    while (!o_frame_done && n < 60) begin
      tick();
      n++;
      checks++;
      if (dvec !== mvec()) begin
        errors++;
        $display("FAIL b2b_first: vec=%h, need %h", dvec, mvec());
      end
    end
    checks++;
    if (!o_frame_done || o_busy !== 1'b0 || o6_step !== 6'd1) begin
      errors++;
      $display("FAIL b2b_gap: done=%b busy=%b step=%0d, need 1 0 1",
               o_frame_done, o_busy, o6_step);
    end
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o6_step !== 6'd5) begin
      errors++;
      $display("FAIL b2b_second: busy=%b step=%0d, need 1 5", o_busy, o6_step);
    end
    for (int j = 0; j < 45; j++) begin
      tick();
      if (o_frame_done) dn++;
      checks++;
      if (dvec !== mvec()) begin
        errors++;
        $display("FAIL b2b_run j=%0d: vec=%h, need %h", j, dvec, mvec());
      end
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL b2b_done2: pulses=%0d, need 1", dn);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    i8_data = 8'h96;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (17) tick();
    i_abort = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o6_step !== 6'd1 || o_frame_done !== 1'b0 ||
        o_mark !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b step=%0d done=%b mark=%b ready=%b, need 0 1 0 0 0",
               o_busy, o6_step, o_frame_done, o_mark, o_ready);
    end
    i_abort = 1'b0;
    for (int j = 0; j < 45; j++) begin
      tick();
      if (o_frame_done) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_nodone: pulses=%0d, need 0", dn);
    end
    i8_data = 8'h5A;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || dvec !== mvec()) begin
      errors++;
      $display("FAIL abort_reaccept: vec=%h, need %h", dvec, mvec());
    end
    repeat (45) tick();
  endtask

  task automatic test_rst_mid();
    i8_data = 8'hE7;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (37) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (o6_mem_index !== 6'd0 || o6_step !== 6'd1 || o_busy !== 1'b0 ||
        o_mark !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: idx=%0d step=%0d busy=%b mark=%b ready=%b, need 0 1 0 0 1",
               o6_mem_index, o6_step, o_busy, o_mark, o_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int j = 0; j < 4000; j++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i8_data = 8'($urandom);
      i_abort = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (dvec !== mvec()) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random j=%0d: vec=%h, need %h", j, dvec, mvec());
      end
    end
    i_valid = 1'b0;
    i_abort = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_frame(8'hA5);
    test_wrap();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
